// File: rtl/atmega_eep_backup.sv
// Persistence engine: loads the EEPROM save image on mount and writes the array
// back sector-by-sector after CPU writes settle or on an explicit save request.
module atmega_eep_backup #(
  parameter int          EEP_SIZE   = 1024,
  parameter int          ADDR_W     = 10,
  parameter logic [23:0] IDLE_DELAY = 24'd4_000_000
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              eep_wr_pulse,
  input  logic              save_req,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [8:0]        sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wr_data,
  output logic              mem_we,
  input  logic [7:0]        mem_rd_data,
  output logic              cpu_hold,
  output logic              busy
);

  localparam int SECTORS = EEP_SIZE / 512;
  localparam int SEC_W   = ADDR_W - 9;

  typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER} state_t;

  state_t            state, state_nxt;
  logic [SEC_W-1:0]  sector;
  logic [23:0]       idle_cnt;
  logic              mounted, readonly, dirty, pend_load, pend_save, ack_q;
  logic              ack_rise, ack_fall, last_sector;
  logic              start_load, start_save, drop_save, next_sector, load_done;

  assign ack_rise    = sd_ack & ~ack_q;
  assign ack_fall    = ~sd_ack & ack_q;
  assign last_sector = (sector == SEC_W'(SECTORS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_load  = 1'b0;
    start_save  = 1'b0;
    drop_save   = 1'b0;
    next_sector = 1'b0;
    load_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_load) begin
          state_nxt  = LOAD_REQ;
          start_load = 1'b1;
        end else if (mounted && !readonly && (pend_save || (dirty && idle_cnt == 24'd0))) begin
          state_nxt  = SAVE_REQ;
          start_save = 1'b1;
        end else if (pend_save) begin
          drop_save  = 1'b1;
        end
      end
      LOAD_REQ:  if (ack_rise) state_nxt = LOAD_XFER;
      LOAD_XFER: begin
        if (ack_fall) begin
          if (last_sector) begin
            state_nxt = IDLE;
            load_done = 1'b1;
          end else begin
            state_nxt   = LOAD_REQ;
            next_sector = 1'b1;
          end
        end
      end
      SAVE_REQ:  if (ack_rise) state_nxt = SAVE_XFER;
      SAVE_XFER: begin
        if (ack_fall) begin
          if (last_sector) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = SAVE_REQ;
            next_sector = 1'b1;
          end
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Requests are registered from the next state so they drop on the ack edge
  // and vanish immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      ack_q     <= 1'b0;
      sector    <= '0;
      mounted   <= 1'b0;
      readonly  <= 1'b0;
      pend_load <= 1'b0;
      pend_save <= 1'b0;
      dirty     <= 1'b0;
      idle_cnt  <= 24'd0;
    end else begin
      sd_rd <= (state_nxt == LOAD_REQ);
      sd_wr <= (state_nxt == SAVE_REQ);
      ack_q <= sd_ack;

      if (start_load || start_save) sector <= '0;
      else if (next_sector)         sector <= sector + SEC_W'(1);

      if (img_mounted) begin
        mounted   <= (img_size >= 64'(EEP_SIZE));
        readonly  <= img_readonly;
        pend_load <= (img_size >= 64'(EEP_SIZE));
      end else if (start_load) begin
        pend_load <= 1'b0;
      end

      if (save_req)                      pend_save <= 1'b1;
      else if (start_save || drop_save)  pend_save <= 1'b0;

      // A CPU write always wins so a write racing a save start is not lost.
      if (eep_wr_pulse)                  dirty <= 1'b1;
      else if (start_save || load_done)  dirty <= 1'b0;

      if (eep_wr_pulse)                        idle_cnt <= IDLE_DELAY;
      else if (dirty && idle_cnt != 24'd0)     idle_cnt <= idle_cnt - 24'd1;
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = 8'd0;
    mem_we      = 1'b0;
    sd_buff_din = 8'd0;
    if (state == LOAD_XFER) begin
      mem_addr    = {sector, sd_buff_addr};
      mem_wr_data = sd_buff_dout;
      mem_we      = sd_buff_wr & sd_ack;
    end else if (state == SAVE_XFER) begin
      mem_addr    = {sector, sd_buff_addr};
      sd_buff_din = mem_rd_data;
    end
  end

  assign sd_lba   = (state == IDLE) ? 32'd0 : 32'(sector);
  assign cpu_hold = (state == LOAD_REQ) || (state == LOAD_XFER) || ((state == IDLE) && pend_load);
  assign busy     = (state != IDLE);

endmodule
